// File: rtl/gate_sweep_pkg.sv
// Shared types and constants for the gate sweep sequencer and its reference model.
package gate_sweep_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int MODE_AND  = 0;
  localparam int MODE_OR   = 1;
  localparam int MODE_XOR  = 2;
  localparam int MODE_NAND = 3;
  localparam int MODE_NOR  = 4;

  // Settle counter width; holds SETTLE_CYC-1 for SETTLE_CYC in 1..15.
  localparam int SETTLE_W = 4;

endpackage

// File: rtl/gate_ref_model.sv
// Combinational golden function of an N_IN-input gate; unknown MODE values fall back to AND.
module gate_ref_model
  import gate_sweep_pkg::*;
#(
  parameter int N_IN = 4,
  parameter int MODE = MODE_AND
) (
  input  logic [N_IN-1:0] vec,
  output logic            exp
);

  always_comb begin
    exp = &vec;
    case (MODE)
      MODE_OR:   exp = |vec;
      MODE_XOR:  exp = ^vec;
      MODE_NAND: exp = ~&vec;
      MODE_NOR:  exp = ~|vec;
      default:   exp = &vec;
    endcase
  end

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Exhaustive ascending-order sweep of a gate-under-test with settle delay, reference compare,
// error count and first-failure capture.
module gate_sweep_ctrl
  import gate_sweep_pkg::*;
#(
  parameter int N_IN       = 4,
  parameter int SETTLE_CYC = 1,
  parameter int MODE       = MODE_AND
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  output logic [N_IN-1:0] vec_o,
  input  logic            y_i,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt,
  output logic [N_IN-1:0] fail_vec,
  output logic            fail_valid
);

  localparam logic [SETTLE_W-1:0] CNT_RELOAD = SETTLE_W'(SETTLE_CYC - 1);

  state_t              r_state,      w_state_nxt;
  logic [N_IN-1:0]     r_vec,        w_vec_nxt;
  logic [SETTLE_W-1:0] r_cnt,        w_cnt_nxt;
  logic [N_IN:0]       r_err,        w_err_nxt;
  logic [N_IN-1:0]     r_fail_vec,   w_fail_vec_nxt;
  logic                r_fail_valid, w_fail_valid_nxt;
  logic                w_exp;
  logic                w_miss;

  gate_ref_model #(
    .N_IN (N_IN),
    .MODE (MODE)
  ) u_ref (
    .vec (r_vec),
    .exp (w_exp)
  );

  // Written so that an unknown y_i lands on the mismatch side.
  always_comb begin
    w_miss = 1'b1;
    if (y_i == w_exp) w_miss = 1'b0;
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_vec_nxt        = r_vec;
    w_cnt_nxt        = r_cnt;
    w_err_nxt        = r_err;
    w_fail_vec_nxt   = r_fail_vec;
    w_fail_valid_nxt = r_fail_valid;
    if (abort) begin
      w_state_nxt      = S_IDLE;
      w_vec_nxt        = '0;
      w_cnt_nxt        = '0;
      w_err_nxt        = '0;
      w_fail_vec_nxt   = '0;
      w_fail_valid_nxt = 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            w_state_nxt      = S_WAIT;
            w_vec_nxt        = '0;
            w_cnt_nxt        = CNT_RELOAD;
            w_err_nxt        = '0;
            w_fail_vec_nxt   = '0;
            w_fail_valid_nxt = 1'b0;
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) w_state_nxt = S_CHECK;
          else             w_cnt_nxt   = r_cnt - 1'b1;
        end
        S_CHECK: begin
          if (w_miss) begin
            w_err_nxt = r_err + 1'b1;
            if (!r_fail_valid) begin
              w_fail_vec_nxt   = r_vec;
              w_fail_valid_nxt = 1'b1;
            end
          end
          if (&r_vec) begin
            w_state_nxt = S_DONE;
          end else begin
            w_vec_nxt   = r_vec + N_IN'(1);
            w_cnt_nxt   = CNT_RELOAD;
            w_state_nxt = S_WAIT;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_vec        <= '0;
      r_cnt        <= '0;
      r_err        <= '0;
      r_fail_vec   <= '0;
      r_fail_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_vec        <= w_vec_nxt;
      r_cnt        <= w_cnt_nxt;
      r_err        <= w_err_nxt;
      r_fail_vec   <= w_fail_vec_nxt;
      r_fail_valid <= w_fail_valid_nxt;
    end
  end

  // Status is a pure decode of registered state, so no input reaches an output combinationally.
  assign vec_o      = r_vec;
  assign busy       = (r_state == S_WAIT) || (r_state == S_CHECK);
  assign done       = (r_state == S_DONE);
  assign pass       = done && (r_err == '0);
  assign err_cnt    = r_err;
  assign fail_vec   = r_fail_vec;
  assign fail_valid = r_fail_valid;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Directed + randomized bench: two sequencers (AND/settle 1, XOR/settle 3) with faultable gates.
module tb_gate_sweep_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        start_a, abort_a, start_b, abort_b;
  logic [3:0]  vec_a, vec_b, fvec_a, fvec_b;
  logic        busy_a, done_a, pass_a, fval_a, y_a;
  logic        busy_b, done_b, pass_b, fval_b, y_b;
  logic [4:0]  err_a, err_b;
  int          ysel_a, ysel_b;
  logic [15:0] mask_a, mask_b;

  int checks = 0;
  int errors = 0;

  gate_sweep_ctrl #(.N_IN(4), .SETTLE_CYC(1), .MODE(0)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .vec_o(vec_a), .y_i(y_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_a), .fail_vec(fvec_a),
    .fail_valid(fval_a));

  gate_sweep_ctrl #(.N_IN(4), .SETTLE_CYC(3), .MODE(2)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .vec_o(vec_b), .y_i(y_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b), .fail_vec(fvec_b),
    .fail_valid(fval_b));

  // Gate truth from the number of ones in the vector.
  function automatic logic gate_fn(input int mode, input logic [3:0] v);
    int ones;
    ones = $countones(v);
    case (mode)
      1: return ones != 0;
      2: return (ones % 2) == 1;
      3: return ones != 4;
      4: return ones == 0;
      default: return ones == 4;
    endcase
  endfunction

  // ysel: 0 = real gate with injected flips from mask, 1 = stuck at 0, 2 = stuck at 1
  function automatic logic gut(input int mode, input int ysel, input logic [15:0] m,
                               input logic [3:0] v);
    if (ysel == 1) return 1'b0;
    if (ysel == 2) return 1'b1;
    return gate_fn(mode, v) ^ m[v];
  endfunction

  always_comb y_a = gut(0, ysel_a, mask_a, vec_a);
  always_comb y_b = gut(2, ysel_b, mask_b, vec_b);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, expv);
    end
  endtask

  task automatic rd(input int d, output logic [3:0] v, output logic b, output logic dn,
                    output logic p, output logic [4:0] e, output logic [3:0] fv,
                    output logic fl);
    if (d == 0) begin v = vec_a; b = busy_a; dn = done_a; p = pass_a; e = err_a; fv = fvec_a; fl = fval_a; end
    else        begin v = vec_b; b = busy_b; dn = done_b; p = pass_b; e = err_b; fv = fvec_b; fl = fval_b; end
  endtask

  task automatic chk_idle(input int d, input string tag);
    logic [3:0] v, fv; logic b, dn, p, fl; logic [4:0] e;
    rd(d, v, b, dn, p, e, fv, fl);
    chk({tag, "_vec"}, 32'(v), 0);
    chk({tag, "_busy"}, 32'(b), 0);
    chk({tag, "_done"}, 32'(dn), 0);
    chk({tag, "_pass"}, 32'(p), 0);
    chk({tag, "_err"}, 32'(e), 0);
    chk({tag, "_fvec"}, 32'(fv), 0);
    chk({tag, "_fval"}, 32'(fl), 0);
  endtask

  // Full sweep: pulse start, optionally trace every cycle, then check final status vs. model.
  task automatic sweep(input int d, input int ysel, input logic [15:0] m, input bit trace,
                       input string tag);
    int s, mode, lat, exp_err, exp_fv;
    bit exp_fl;
    logic [3:0] v, fv; logic b, dn, p, fl; logic [4:0] e;
    s    = (d == 0) ? 1 : 3;
    mode = (d == 0) ? 0 : 2;
    lat  = 16 * (s + 1);
    exp_err = 0; exp_fv = 0; exp_fl = 0;
    for (int x = 0; x < 16; x++) begin
      if (gut(mode, ysel, m, 4'(x)) != gate_fn(mode, 4'(x))) begin
        exp_err++;
        if (!exp_fl) begin exp_fl = 1; exp_fv = x; end
      end
    end
    if (d == 0) begin ysel_a = ysel; mask_a = m; start_a = 1'b1; end
    else        begin ysel_b = ysel; mask_b = m; start_b = 1'b1; end
    tick();
    start_a = 1'b0; start_b = 1'b0;
    for (int k = 0; k < lat; k++) begin
      if (k > 0) tick();
      rd(d, v, b, dn, p, e, fv, fl);
      if (k == 0) chk({tag, "_err_clr"}, 32'(e), 0);
      if (trace) begin
        chk({tag, "_tr_vec"}, 32'(v), 32'(k / (s + 1)));
        chk({tag, "_tr_busy"}, 32'(b), 1);
      end
      if (k == lat - 1) chk({tag, "_done_early"}, 32'(dn), 0);
    end
    tick();
    rd(d, v, b, dn, p, e, fv, fl);
    chk({tag, "_done"}, 32'(dn), 1);
    chk({tag, "_busy"}, 32'(b), 0);
    chk({tag, "_vec_hold"}, 32'(v), 15);
    chk({tag, "_err"}, 32'(e), 32'(exp_err));
    chk({tag, "_fval"}, 32'(fl), 32'(exp_fl));
    chk({tag, "_fvec"}, 32'(fv), 32'(exp_fv));
    chk({tag, "_pass"}, 32'(p), 32'(exp_err == 0));
  endtask

  initial begin
    logic [15:0] m;
    rst_n = 1'b0;
    start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
    ysel_a = 0; ysel_b = 0; mask_a = '0; mask_b = '0;
    tick(); tick();
    rst_n = 1'b1;
    chk_idle(0, "rst_a");
    chk_idle(1, "rst_b");

    sweep(0, 0, 16'h0, 1'b1, "and_good");
    sweep(0, 1, 16'h0, 1'b0, "tie0");
    sweep(0, 2, 16'h0, 1'b0, "tie1");

    // Abort out of DONE clears status.
    abort_a = 1'b1; tick(); abort_a = 1'b0;
    chk_idle(0, "abort_done");

    for (int r = 0; r < 4; r++) begin
      m = 16'($urandom);
      sweep(0, 0, m, 1'b0, "and_rand");
    end

    // Restart during the sweep is ignored; abort then clears everything.
    m = 16'($urandom) | 16'h0001;
    ysel_a = 0; mask_a = m; start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int k = 1; k <= 19; k++) begin
      tick();
      start_a = (k == 10);
    end
    chk("ign_vec", 32'(vec_a), 9);
    chk("ign_busy", 32'(busy_a), 1);
    chk("ign_err", 32'(err_a), 32'($countones(m[8:0])));
    abort_a = 1'b1; tick(); abort_a = 1'b0;
    chk_idle(0, "abort_mid");

    // abort wins over start in the same cycle.
    start_a = 1'b1; abort_a = 1'b1; tick(); start_a = 1'b0; abort_a = 1'b0;
    chk_idle(0, "abort_prio");

    // Reset mid-sweep at vec 6, then a fresh sweep starts from 0.
    mask_a = 16'($urandom); start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int k = 1; k <= 12; k++) tick();
    chk("pre_rst_vec", 32'(vec_a), 6);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk_idle(0, "rst_mid");
    sweep(0, 0, 16'($urandom), 1'b1, "after_rst");

    sweep(1, 0, 16'h0, 1'b1, "xor_good");
    sweep(1, 0, 16'($urandom) | 16'h8000, 1'b0, "xor_rand");
    sweep(1, 0, 16'h0, 1'b1, "xor_again");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
